keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Drives the 4x4 hex keypad columns and reads its rows, the board-side end of the fil/col interface.
//  Debounces the raw keypad signals and emits one decoded 4-bit hex code per physical key press.
//  Feeds the operand-entry logic of the divider top, which consumes key_valid/key_code nibbles.
// PARAMETERS
//  SCAN_DIV      1000   clk cycles each column is driven low before its rows are sampled (>=4)
//  DEBOUNCE_CYC  50000  consecutive stable cycles required to accept a press or a release (>=2)
//  REPEAT_DELAY  25e6   cycles held before the first auto-repeat (only used with KEY_REPEAT_EN)
//  REPEAT_PERIOD 5e6    cycles between later auto-repeats (only used with KEY_REPEAT_EN)
// PORTS
//  clk        in   1  system clock (50 MHz)
//  rst        in   1  asynchronous reset, active-high
//  fil        in   4  keypad rows, active-low; pulled up, idle 4'hF
//  col        out  4  keypad columns, one-hot active-low drive
//  key_code   out  4  hex code of the last accepted key; holds until the next accepted key
//  key_valid  out  1  single-cycle pulse when key_code is updated
//  key_held   out  1  high from acceptance until the release is accepted
// BEHAVIOUR
//  Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, all counters=0.
//  fil passes through a 2-FF synchronizer (fil_s) before any use; it adds 2 cycles of latency.
//  SCAN: col rotates 1110->1101->1011->0111->1110, advancing every SCAN_DIV cycles.
//   On the last cycle of each column period, fil_s is sampled. Exactly one bit low -> latch (row, col) -> DEBOUNCE.
//   All bits high, or two or more bits low (ghost/multi-key) -> keep scanning, no output.
//  DEBOUNCE: col frozen. The counter counts cycles with fil_s equal to the latched value.
//   Any mismatch -> back to SCAN at the next column, counter cleared.
//   Counter reaches DEBOUNCE_CYC -> key_code=map(row,col), key_valid=1 for one cycle, key_held=1 -> HOLD.
//  HOLD: col frozen. When fil_s==4'hF -> RELEASE. Other row changes are ignored (no new code while held).
//  RELEASE: counts cycles with fil_s==4'hF. Any low bit -> back to HOLD, counter cleared.
//   Reaching DEBOUNCE_CYC -> key_held=0 -> SCAN at the next column.
//  Map (row r = fil bit index, col c = col bit index):
//   r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: E(*) 0 F(#) D.
//  Latency from a stable press reaching fil_s in the sampled column to key_valid: DEBOUNCE_CYC+1 cycles.
//  rst mid-press: all state is cleared immediately. A key still down is re-detected from SCAN and reported once more.
//  key_valid never asserts on two consecutive cycles. key_code is stable while key_valid=1.
// CONFIGURATION
//  KEY_REPEAT_EN defined: in HOLD, a repeat counter runs. After REPEAT_DELAY cycles, key_valid pulses again
//   with the same key_code, then again every REPEAT_PERIOD cycles until release. The counter clears on entering HOLD.
//  Undefined: exactly one key_valid per press. REPEAT_* parameters are ignored and the repeat counter is not synthesized.
// STRUCTURE
//  keypad_pkg: typedef enum {SCAN, DEBOUNCE, HOLD, RELEASE} kp_state_t; 16-entry constant KEY_MAP[row][col].
//   Also holds helpers onehot_low(fil) and idx_of(fil).
//  One sub-module, kp_sync2, the 2-FF synchronizer for fil (async-reset to 4'hF).
//  FSM and counters stay inline in keypad_scanner.
// TESTING (SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_DELAY=40, REPEAT_PERIOD=16)
//  Reset: rst=1 -> col=1110, key_code=0, key_valid=0, key_held=0. Idle fil=F for 100 cycles -> col rotates, no key_valid.
//  Press model drives fil[0]=0 only while col[1]=0, held 60 cycles -> one key_valid, key_code=4'h2, key_held=1;
//   release -> key_held=0 after 8+ stable cycles.
//  Bounce: fil[3] toggles low/high every 3 cycles for 30 cycles while col[3]=0, then steady low -> exactly one key_valid, key_code=4'hD.
//  Ghost: fil[1] and fil[2] both low on col[0] -> no key_valid; col keeps rotating.
//  Sequence: keys 4, 5, 0, 7 pressed and released in turn -> key_valid pulses with codes 4, 5, 0, 7 in order.
//   This is the 4-nibble operand entry for A=0x45, B=0x07.
//  Reset mid-HOLD: rst pulsed while key 9 is held -> outputs cleared at once; after rst, key 9 is reported once.
//   KEY_REPEAT_EN: hold key 6 for 100 cycles -> pulses at acceptance, +40, +56, +72, +88.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and decode helpers for the 4x4 hex keypad scanner.
// Rows (fil) and columns (col) are both active-low on the board.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2,
      RELEASE  = 2'd3
   } kp_state_t;

   // KEY_MAP[row][col]; the concatenation lists row 3 first, and col 3 first within each row.
   localparam logic [3:0][3:0][3:0] KEY_MAP = {
      {4'hD, 4'hF, 4'h0, 4'hE},
      {4'hC, 4'h9, 4'h8, 4'h7},
      {4'hB, 4'h6, 4'h5, 4'h4},
      {4'hA, 4'h3, 4'h2, 4'h1}
   };

   function automatic logic onehot_low(input logic [3:0] f);
      logic [3:0] low;
      low = ~f;
      return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] idx_of(input logic [3:0] f);
      logic [1:0] idx;
      case (f)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchronizer for the keypad row inputs; resets to the idle
// (all rows released) pattern so the scanner never sees a phantom press.
module kp_sync2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta_q, meta_d;
   logic [3:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 4'hF;
         sync_q <= 4'hF;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column drive, debounce, decode, one key_valid per press.
// Define KEY_REPEAT_EN to add auto-repeat of the held key.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV      = 1000,
   parameter int DEBOUNCE_CYC  = 50000,
   parameter int REPEAT_DELAY  = 25_000_000,
   parameter int REPEAT_PERIOD = 5_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] fil,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);

   logic [3:0]    fil_s;
   kp_state_t     state_q, state_d;
   logic [1:0]    col_idx_q, col_idx_d;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [3:0]    pat_q, pat_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          key_held_q, key_held_d;

`ifdef KEY_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(REP_MAX + 1);
   logic [RW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rep_phase_q, rep_phase_d;
   logic          rep_hit;
`endif

   kp_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (fil),
      .q   (fil_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SCAN;
         col_idx_q   <= 2'd0;
         scan_cnt_q  <= '0;
         deb_cnt_q   <= '0;
         pat_q       <= 4'hF;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         scan_cnt_q  <= scan_cnt_d;
         deb_cnt_q   <= deb_cnt_d;
         pat_q       <= pat_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
`ifdef KEY_REPEAT_EN
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
`endif
      end
   end

`ifdef KEY_REPEAT_EN
   assign rep_hit = rep_phase_q ? (rep_cnt_q == RW'(REPEAT_PERIOD - 1))
                                : (rep_cnt_q == RW'(REPEAT_DELAY - 1));
`endif

   always_comb begin
      state_d     = state_q;
      col_idx_d   = col_idx_q;
      scan_cnt_d  = scan_cnt_q;
      deb_cnt_d   = deb_cnt_q;
      pat_d       = pat_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
`ifdef KEY_REPEAT_EN
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
`endif
      case (state_q)
         SCAN: begin
            if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
               scan_cnt_d = '0;
               // Multi-key (ghost) and idle patterns both just move on to the next column.
               if (onehot_low(fil_s)) begin
                  state_d   = DEBOUNCE;
                  pat_d     = fil_s;
                  deb_cnt_d = '0;
               end else begin
                  col_idx_d = col_idx_q + 2'd1;
               end
            end else begin
               scan_cnt_d = scan_cnt_q + SW'(1);
            end
         end
         DEBOUNCE: begin
            if (fil_s != pat_q) begin
               state_d    = SCAN;
               col_idx_d  = col_idx_q + 2'd1;
               scan_cnt_d = '0;
               deb_cnt_d  = '0;
            end else if (deb_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
               state_d     = HOLD;
               deb_cnt_d   = '0;
               key_code_d  = KEY_MAP[idx_of(pat_q)][col_idx_q];
               key_valid_d = 1'b1;
               key_held_d  = 1'b1;
`ifdef KEY_REPEAT_EN
               rep_cnt_d   = '0;
               rep_phase_d = 1'b0;
`endif
            end else begin
               deb_cnt_d = deb_cnt_q + DW'(1);
            end
         end
         HOLD: begin
            if (fil_s == 4'hF) begin
               state_d   = RELEASE;
               deb_cnt_d = '0;
`ifdef KEY_REPEAT_EN
            end else if (rep_hit) begin
               key_valid_d = 1'b1;
               rep_cnt_d   = '0;
               rep_phase_d = 1'b1;
            end else begin
               rep_cnt_d = rep_cnt_q + RW'(1);
`endif
            end
         end
         RELEASE: begin
            if (fil_s != 4'hF) begin
               state_d   = HOLD;
               deb_cnt_d = '0;
`ifdef KEY_REPEAT_EN
               rep_cnt_d   = '0;
               rep_phase_d = 1'b0;
`endif
            end else if (deb_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
               state_d    = SCAN;
               deb_cnt_d  = '0;
               key_held_d = 1'b0;
               col_idx_d  = col_idx_q + 2'd1;
               scan_cnt_d = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + DW'(1);
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_comb begin
      col       = ~(4'b0001 << col_idx_q);
      key_code  = key_code_q;
      key_valid = key_valid_q;
      key_held  = key_held_q;
   end

   param_range_a: assert property (@(posedge clk) disable iff (rst)
      (SCAN_DIV >= 4) && (DEBOUNCE_CYC >= 2) && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 2));

   no_back_to_back_a: assert property (@(posedge clk) disable iff (rst)
      key_valid_q |=> !key_valid_q);

endmodule
